// File: rtl/sys_top_pkg.sv
// sys_top_pkg: command opcodes, ALU functions,
// command FSM states and config register layout.
package sys_top_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'hAA;
    localparam logic [7:0] CMD_READ   = 8'hBB;
    localparam logic [7:0] CMD_ALU    = 8'hCC;
    localparam logic [7:0] CMD_ALU_RF = 8'hDD;

    localparam int         CFG_REG     = 2;
    localparam int         CFG_PAR_EN  = 0;
    localparam int         CFG_PAR_TYP = 1;
    localparam logic [7:0] CFG_RESET   = 8'h01;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV,
        ALU_AND, ALU_OR, ALU_NAND, ALU_NOR,
        ALU_XOR, ALU_XNOR, ALU_EQ, ALU_GT,
        ALU_LT, ALU_SHR, ALU_SHL, ALU_ZERO
    } alu_func_e;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
        S_ALU_A, S_ALU_B, S_ALU_FUNC, S_EXEC,
        S_TX_WAIT
    } state_e;

endpackage

// File: rtl/sys_top_uart_rx.sv
// uart_rx: mid-bit sampling receiver with optional parity.
// Emits a byte pulse or an error pulse at the stop-bit sample.
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  par_en,
    input  logic                  par_odd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  err,
    output logic                  rx_error
);
    import sys_top_pkg::*;

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam int              BW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_e;

    rx_state_e             st;
    logic [2:0]            sync;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         idx;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par_ok;

    // Synchronise the line, then walk the frame one bit at a time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= R_IDLE;
            sync     <= '1;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            par_ok   <= 1'b1;
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            sync  <= {sync[1:0], rx};
            valid <= 1'b0;
            err   <= 1'b0;
            unique case (st)
                R_IDLE: begin
                    if (sync[2] && !sync[1]) begin
                        st  <= R_START;
                        cnt <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (sync[1]) begin
                            st <= R_IDLE;
                        end else begin
                            st       <= R_DATA;
                            idx      <= '0;
                            par_ok   <= 1'b1;
                            rx_error <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        sh  <= {sync[1], sh[DATA_WIDTH-1:1]};
                        idx <= idx + 1'b1;
                        if (idx == LAST)
                            st <= par_en ? R_PAR : R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_PAR: begin
                    if (cnt == FULL) begin
                        cnt    <= '0;
                        par_ok <= (sync[1] == ((^sh) ^ par_odd));
                        st     <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        st  <= R_IDLE;
                        if (sync[1] && par_ok) begin
                            valid <= 1'b1;
                            data  <= sh;
                        end else begin
                            err      <= 1'b1;
                            rx_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sys_top.sv
// sys_top: UART command processor driving a register
// file and ALU, replying with serial frames.
module sys_top #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int RF_DEPTH     = 16
) (
    input  logic REF_CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT,
    output logic RX_ERROR
);
    import sys_top_pkg::*;

    localparam int AW = $clog2(RF_DEPTH);
    localparam int RW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(DATA_WIDTH + 4);
    localparam logic [CW-1:0]         FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [DATA_WIDTH-1:0] DEPTH = DATA_WIDTH'(RF_DEPTH);

    logic [DATA_WIDTH-1:0] rf [RF_DEPTH];
    state_e                state;
    alu_func_e             func;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] hi_byte;
    logic                  two;
    logic                  hi_pend;

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_err;
    logic                  par_en;
    logic                  par_odd;

    logic                  addr_ok;
    logic [AW-1:0]         ridx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [RW-1:0]         wa;
    logic [RW-1:0]         wb;
    logic [RW-1:0]         alu_res;
    logic                  collecting;

    logic [DATA_WIDTH+2:0] tx_sr;
    logic [LW-1:0]         tx_left;
    logic [CW-1:0]         tx_cnt;
    logic                  tx_last;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_byte;

    assign par_en  = rf[CFG_REG][CFG_PAR_EN];
    assign par_odd = rf[CFG_REG][CFG_PAR_TYP];
    assign addr_ok = addr < DEPTH;
    assign ridx    = addr[AW-1:0];
    assign rd_data = addr_ok ? rf[ridx] : '0;
    assign collecting = state inside {S_WR_ADDR, S_WR_DATA,
        S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUNC};

    uart_rx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (REF_CLK),
        .rst_n   (RST),
        .rx      (RX_IN),
        .par_en  (par_en),
        .par_odd (par_odd),
        .data    (rx_data),
        .valid   (rx_valid),
        .err     (rx_err),
        .rx_error(RX_ERROR)
    );

    // Unsigned ALU over RF[0]/RF[1], result modulo 2^RW
    always_comb begin
        wa      = RW'(rf[0]);
        wb      = RW'(rf[1]);
        alu_res = '0;
        unique case (func)
            ALU_ADD:  alu_res = wa + wb;
            ALU_SUB:  alu_res = wa - wb;
            ALU_MUL:  alu_res = wa * wb;
            ALU_DIV:  alu_res = (wb == '0) ? '0 : wa / wb;
            ALU_AND:  alu_res = wa & wb;
            ALU_OR:   alu_res = wa | wb;
            ALU_NAND: alu_res = RW'(~(rf[0] & rf[1]));
            ALU_NOR:  alu_res = RW'(~(rf[0] | rf[1]));
            ALU_XOR:  alu_res = wa ^ wb;
            ALU_XNOR: alu_res = RW'(~(rf[0] ^ rf[1]));
            ALU_EQ:   alu_res = RW'(wa == wb);
            ALU_GT:   alu_res = RW'(wa > wb);
            ALU_LT:   alu_res = RW'(wa < wb);
            ALU_SHR:  alu_res = wa >> 1;
            ALU_SHL:  alu_res = wa << 1;
            ALU_ZERO: alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

    // The high byte loads in the stop bit's last cycle: no idle gap
    assign tx_last = (tx_left == LW'(1)) && (tx_cnt == FULL);
    assign tx_load = (state == S_EXEC) ||
                     ((state == S_TX_WAIT) && tx_last && hi_pend);
    assign tx_byte = (state != S_EXEC) ? hi_byte :
                     two ? alu_res[DATA_WIDTH-1:0] : rd_data;
    assign TX_OUT  = tx_sr[0];

    // Serialiser: start, data LSB first, parity, stop
    always_ff @(posedge REF_CLK) begin
        if (!RST) begin
            tx_sr   <= '1;
            tx_left <= '0;
            tx_cnt  <= '0;
        end else if (tx_load) begin
            tx_sr   <= {1'b1,
                        par_en ? ((^tx_byte) ^ par_odd) : 1'b1,
                        tx_byte, 1'b0};
            tx_left <= par_en ? LW'(DATA_WIDTH + 3) : LW'(DATA_WIDTH + 2);
            tx_cnt  <= '0;
        end else if (tx_left != '0) begin
            if (tx_cnt == FULL) begin
                tx_cnt  <= '0;
                tx_sr   <= {1'b1, tx_sr[DATA_WIDTH+2:1]};
                tx_left <= tx_left - 1'b1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // Command sequencer: collects bytes, updates RF, hands off to TX
    always_ff @(posedge REF_CLK) begin
        if (!RST) begin
            state   <= S_IDLE;
            func    <= ALU_ADD;
            addr    <= '0;
            hi_byte <= '0;
            two     <= 1'b0;
            hi_pend <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++)
                rf[i] <= '0;
            rf[CFG_REG] <= DATA_WIDTH'(CFG_RESET);
        end else if (rx_err && collecting) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_WRITE:  state <= S_WR_ADDR;
                            CMD_READ:   state <= S_RD_ADDR;
                            CMD_ALU:    state <= S_ALU_A;
                            CMD_ALU_RF: state <= S_ALU_FUNC;
                            default:    state <= S_IDLE;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (rx_valid) begin
                        addr  <= rx_data;
                        state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (rx_valid) begin
                        if (addr_ok)
                            rf[ridx] <= rx_data;
                        state <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (rx_valid) begin
                        addr  <= rx_data;
                        two   <= 1'b0;
                        state <= S_EXEC;
                    end
                end
                S_ALU_A: begin
                    if (rx_valid) begin
                        rf[0] <= rx_data;
                        state <= S_ALU_B;
                    end
                end
                S_ALU_B: begin
                    if (rx_valid) begin
                        rf[1] <= rx_data;
                        state <= S_ALU_FUNC;
                    end
                end
                S_ALU_FUNC: begin
                    if (rx_valid) begin
                        func  <= alu_func_e'(rx_data[3:0]);
                        two   <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    hi_byte <= alu_res[RW-1:DATA_WIDTH];
                    hi_pend <= two;
                    state   <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (tx_last) begin
                        if (hi_pend)
                            hi_pend <= 1'b0;
                        else
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_top.sv
// tb_sys_top: directed serial command tests for sys_top.
// Fast bit rate keeps the run short.
module tb_sys_top;
    import sys_top_pkg::*;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_in = 1'b1;
    logic tx_out;
    logic rx_error;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    frame_t mon_q[$];

    sys_top #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB),
        .RF_DEPTH    (16)
    ) dut (
        .REF_CLK (clk),
        .RST     (rst_n),
        .RX_IN   (rx_in),
        .TX_OUT  (tx_out),
        .RX_ERROR(rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decodes every frame on tx_out into mon_q
    initial begin : tx_mon
        frame_t f;
        logic   prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx_out) begin
                f.start = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.data[i] = tx_out;
                end
                repeat (CPB) @(negedge clk);
                f.par = tx_out;
                repeat (CPB) @(negedge clk);
                f.stp = tx_out;
                mon_q.push_back(f);
            end
            prev = tx_out;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic odd,
                             input logic flip);
        logic [10:0] fr;
        fr = {1'b1, (^b) ^ odd ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_in = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int limit);
        for (int i = 0; i < limit && mon_q.size() < n; i++)
            @(negedge clk);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_tx got %b want 1", tx_out);
        end
        checks++;
        if (rx_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_rxerr got %b want 0", rx_error);
        end
        checks++;
        if (dut.rf[2] !== 8'h01) begin
            errors++;
            $display("FAIL rst_cfg got %h want 01", dut.rf[2]);
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL rst_state got %0d want IDLE", dut.state);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        mon_q.delete();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'hA6, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (dut.rf[5] !== 8'hA6) begin
            errors++;
            $display("FAIL wr_rf5 got %h want a6", dut.rf[5]);
        end
        checks++;
        if (mon_q.size() != 0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL wr_quiet got %0d frames want 0", mon_q.size());
        end
        checks++;
        if (rx_error !== 1'b0) begin
            errors++;
            $display("FAIL wr_rxerr got %b want 0", rx_error);
        end
    endtask

    task automatic test_read;
        mon_q.delete();
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        wait_frames(1, 20 * CPB);
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL rd_count got %0d want 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].data !== 8'hA6 || mon_q[0].par !== 1'b0 ||
                mon_q[0].stp !== 1'b1) begin
                errors++;
                $display("FAIL rd_frame got %h/%b/%b want a6/0/1",
                         mon_q[0].data, mon_q[0].par, mon_q[0].stp);
            end
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL rd_idle got %0d want IDLE", dut.state);
        end
    endtask

    task automatic test_alu(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] fn,
                            input logic odd, input logic [15:0] want);
        mon_q.delete();
        send_byte(op, odd, 1'b0);
        if (op == 8'hCC) begin
            send_byte(a, odd, 1'b0);
            send_byte(b, odd, 1'b0);
        end
        send_byte(fn, odd, 1'b0);
        wait_frames(2, 40 * CPB);
        checks++;
        if (mon_q.size() != 2) begin
            errors++;
            $display("FAIL alu_count got %0d want 2", mon_q.size());
        end else begin
            checks++;
            if ({mon_q[1].data, mon_q[0].data} !== want) begin
                errors++;
                $display("FAIL alu_res got %h%h want %h",
                         mon_q[1].data, mon_q[0].data, want);
            end
            checks++;
            if (mon_q[1].start - mon_q[0].start != 11 * CPB) begin
                errors++;
                $display("FAIL alu_b2b got %0d want %0d",
                         mon_q[1].start - mon_q[0].start, 11 * CPB);
            end
        end
        checks++;
        if (dut.rf[0] !== a || dut.rf[1] !== b) begin
            errors++;
            $display("FAIL alu_ops got %h %h want %h %h",
                     dut.rf[0], dut.rf[1], a, b);
        end
    endtask

    task automatic test_rx_error;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        checks++;
        if (rx_error !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", rx_error);
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL err_abort got %0d want IDLE", dut.state);
        end
        send_byte(8'h07, 1'b0, 1'b0);
        checks++;
        if (rx_error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", rx_error);
        end
        send_byte(8'h99, 1'b0, 1'b0);
        checks++;
        if (dut.rf[7] !== 8'h00) begin
            errors++;
            $display("FAIL err_rf7 got %h want 00", dut.rf[7]);
        end
    endtask

    task automatic test_odd_parity;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        checks++;
        if (dut.rf[2] !== 8'h03) begin
            errors++;
            $display("FAIL odd_cfg got %h want 03", dut.rf[2]);
        end
        mon_q.delete();
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        wait_frames(1, 20 * CPB);
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL odd_count got %0d want 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].data !== 8'hA6 || mon_q[0].par !== 1'b1) begin
                errors++;
                $display("FAIL odd_frame got %h/%b want a6/1",
                         mon_q[0].data, mon_q[0].par);
            end
        end
    endtask

    task automatic test_boundary;
        mon_q.delete();
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b0);
        wait_frames(1, 20 * CPB);
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL oob_count got %0d want 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0].data !== 8'h00 || mon_q[0].par !== 1'b1) begin
                errors++;
                $display("FAIL oob_rd got %h/%b want 00/1",
                         mon_q[0].data, mon_q[0].par);
            end
        end
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        checks++;
        if (dut.rf[0] !== 8'd40) begin
            errors++;
            $display("FAIL oob_wr got %h want 28", dut.rf[0]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int seen;
        mon_q.delete();
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 4 * CPB && seen == 0; i++) begin
            if (tx_out === 1'b0) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL mid_start got none want start bit");
        end
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || dut.rf[2] !== 8'h01) begin
            errors++;
            $display("FAIL mid_rst got %b/%h want 1/01",
                     tx_out, dut.rf[2]);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu(8'hCC, 8'd40, 8'd30, 8'h01, 1'b0, 16'h000A);
        test_alu(8'hDD, 8'd40, 8'd30, 8'h02, 1'b0, 16'h04B0);
        test_rx_error();
        test_odd_parity();
        test_boundary();
        test_alu(8'hCC, 8'h81, 8'h00, 8'h0E, 1'b1, 16'h0102);
        test_alu(8'hDD, 8'h81, 8'h00, 8'h03, 1'b1, 16'h0000);
        test_alu(8'hCC, 8'd40, 8'd30, 8'h01, 1'b1, 16'h000A);
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
